store_capture_fifo: RTL

//  Sits directly downstream of the CPU top-level and consumes its store port
//  (memwrite, dataadr, writedata, opcode).

---
 rtl/store_capture_fifo.sv | 95 +++++++++
 1 files changed

// File: rtl/store_capture_fifo.sv
// Captures CPU stores that hit the MMIO window into a show-ahead FIFO and
// drains them to a peripheral sink over valid/ready; the CPU is never stalled.
module store_capture_fifo #(
   parameter int unsigned DEPTH     = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0080,
   parameter logic [31:0] WIN_BYTES = 32'h0000_0040
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       memwrite,
   input  logic [31:0]                dataadr,
   input  logic [31:0]                writedata,
   input  logic [5:0]                 opcode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_addr,
   output logic [31:0]                out_data,
   output logic [3:0]                 out_be,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [5:0] OP_SB = 6'b101000;

   // Stored entry layout: {word address [31:2], data, byte enables}
   typedef struct packed {
      logic [29:0] wadr;
      logic [31:0] data;
      logic [3:0]  be;
   } entry_t;

   // Window bound computed in 33 bits so a window ending at 2^32 still works.
   function automatic logic in_window(input logic [31:0] a);
      logic [32:0] lim;
      lim = {1'b0, BASE_ADDR} + {1'b0, WIN_BYTES};
      return (a >= BASE_ADDR) && ({1'b0, a} < lim);
   endfunction

   function automatic logic [3:0] form_be(input logic [5:0] op, input logic [1:0] lane);
      return (op == OP_SB) ? (4'b0001 << lane) : 4'b1111;
   endfunction

   function automatic logic [31:0] form_data(input logic [5:0] op, input logic [31:0] wd);
      return (op == OP_SB) ? {4{wd[7:0]}} : wd;
   endfunction

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            match, push, pop;
   entry_t          head, new_entry;

   assign match     = memwrite & in_window(dataadr);
   assign full      = (count == CW'(DEPTH));
   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   assign push      = match & (~full | pop);

   assign new_entry.wadr = dataadr[31:2];
   assign new_entry.data = form_data(opcode, writedata);
   assign new_entry.be   = form_be(opcode, dataadr[1:0]);

   assign head     = mem[rd_ptr];
   assign out_addr = {head.wadr, 2'b00};
   assign out_data = head.data;
   assign out_be   = head.be;

   // Storage carries no reset; only the control state below is cleared.
   always_ff @(posedge clk) begin
      if (push && !reset)
         mem[wr_ptr] <= new_entry;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (match && full && !pop)
            overflow <= 1'b1;
      end
   end

endmodule
